axi_lite_data_mem: RTL and testbench
====================================

Name: axi_lite_data_mem

Overview:
- Word-organised on-chip memory exposed as an AXI4-Lite slave.
- Sits directly downstream of the CPU/control-module pair and terminates the core's M_AXI_* master port, serving instruction fetches and load/store traffic.
- Read and write channels are independent, with one outstanding transaction per channel.
- Out-of-window accesses return SLVERR.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words; power of two, ≥ 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to MEM_DEPTH*4.
- WAIT_CYCLES, 2, extra response delay in cycles; used only with AXI_MEM_WAIT_EN.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RSTn  in  1  synchronous active-low reset.
- S_AXI_AWVALID/AWREADY  in/out  1/1  write-address handshake.
- S_AXI_AWADDR  in  32  byte address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_WVALID/WREADY  in/out  1/1  write-data handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables; bit i enables WDATA[8i+7:8i].
- S_AXI_BVALID/BREADY  out/in  1/1  write-response handshake.
- S_AXI_BRESP  out  2  OKAY=2'b00, SLVERR=2'b10.
- S_AXI_ARVALID/ARREADY  in/out  1/1  read-address handshake.
- S_AXI_ARADDR  in  32  byte address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_RVALID/RREADY  out/in  1/1  read-data handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  OKAY/SLVERR.

Behaviour:
- Reset (RSTn=0 at a CLK edge):
  - All ready/valid outputs 0; BRESP=RRESP=2'b00; RDATA=0.
  - Captured AW/W flags and read state cleared.
  - Memory contents are not cleared.
  - Reset mid-transaction abandons it; no response is issued afterwards.
- Address decode:
  - word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
  - In range iff BASE_ADDR ≤ addr < BASE_ADDR + MEM_DEPTH*4.
- Write FSM, states W_IDLE, W_RESP:
  - W_IDLE:
    - AWREADY=1 until AW is captured; WREADY=1 until W is captured.
    - AW and W may arrive in the same cycle or in either order; each is latched independently.
  - Cycle in which both are held (captured or handshaking now):
    - Memory written on that edge for each set WSTRB bit if in range.
    - Out of range: no write, BRESP=SLVERR.
    - Next cycle: BVALID=1, state W_RESP, AWREADY=WREADY=0.
  - W_RESP: hold BVALID and BRESP until BREADY; on handshake return to W_IDLE, where AWREADY/WREADY are 1 again the following cycle.
  - WSTRB=0 in range: no bytes change, BRESP=OKAY.
- Read FSM, states R_IDLE, R_RESP:
  - R_IDLE: ARREADY=1. On the AR handshake, the next cycle has RVALID=1 and RDATA=mem[index] (latency 1), or RDATA=0 with RRESP=SLVERR when out of range.
  - R_RESP: ARREADY=0; RDATA/RRESP stable while RVALID && !RREADY. Return to R_IDLE on the handshake.
- Read/write collision: a read and a write to the same word on the same edge returns the old data (read-before-write).
- Response visibility: BVALID and RVALID are never asserted combinationally from input valids; minimum one cycle from handshake to response.
- Throughput: one transaction per channel per 2 cycles with ready held high.

Optional Feature:
- AXI_MEM_WAIT_EN defined:
  - Each FSM gains a WAIT state between capture and response.
  - A counter loads WAIT_CYCLES and decrements to 0, then asserts BVALID/RVALID.
  - Latency from handshake to valid is 1+WAIT_CYCLES; ARREADY/AWREADY/WREADY stay 0 during WAIT.
  - WAIT_CYCLES=0 behaves as not defined.
- AXI_MEM_WAIT_EN not defined: no WAIT state, no counter; latency exactly 1.

Test Plan:
- Write 0xDEADBEEF to 0x10 with WSTRB=4'hF, AW and W in the same cycle -> BVALID one cycle later, BRESP=00. Read 0x10 -> RVALID next cycle, RDATA=0xDEADBEEF, RRESP=00.
- W presented 3 cycles before AW, WSTRB=4'b0010, WDATA=0x0000AB00 on a word holding 0x11223344 -> read returns 0x1122AB44; WREADY drops after W capture while AWREADY stays 1.
- Read and write at BASE_ADDR+MEM_DEPTH*4 -> RRESP=10, RDATA=0, BRESP=10; word 0 unchanged.
- Hold RREADY=0 for 5 cycles after RVALID -> RDATA/RRESP stable, ARREADY=0 throughout; a new ARVALID is accepted only after the R handshake.
- Pull RSTn low for one cycle while BVALID=1 -> BVALID=0 next cycle, no stale response after reset; a fresh write completes normally.
- With AXI_MEM_WAIT_EN and WAIT_CYCLES=3 -> RVALID exactly 4 cycles after the AR handshake; ARREADY=0 during wait.

Source files
------------

// File: rtl/axi_lite_data_mem.sv
// Word-organised AXI4-Lite slave memory with independent read/write channels.
// Optional AXI_MEM_WAIT_EN adds WAIT_CYCLES of extra response latency per channel.
module axi_lite_data_mem #(
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [2:0]  S_AXI_AWPROT,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  output logic [1:0]  S_AXI_BRESP,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [2:0]  S_AXI_ARPROT,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP
);

  localparam int unsigned IDX_W       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] WIN_BYTES   = 32'(MEM_DEPTH * 4);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

`ifdef AXI_MEM_WAIT_EN
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  logic [CNT_W-1:0] w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
`else
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;
`endif

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;

  logic             aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
  logic             aw_hit_q, aw_hit_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             awready_q, awready_d, wready_q, wready_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]       rresp_q, rresp_d;
  logic [31:0]      rdata_q;

  logic             aw_hs, w_hs, ar_hs, have_aw, have_w;
  logic             mem_we, wr_hit, rd_load;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;
  logic [3:0]       wr_strb;

  logic [31:0] mem [MEM_DEPTH];

  // Window decode: subtraction wraps addresses below BASE_ADDR out of range too
  logic [31:0]      aw_off, ar_off;
  logic             aw_hit, ar_hit;
  logic [IDX_W-1:0] aw_idx, ar_idx;
  assign aw_off = S_AXI_AWADDR - BASE_ADDR;
  assign ar_off = S_AXI_ARADDR - BASE_ADDR;
  assign aw_hit = aw_off < WIN_BYTES;
  assign ar_hit = ar_off < WIN_BYTES;
  assign aw_idx = aw_off[IDX_W+1:2];
  assign ar_idx = ar_off[IDX_W+1:2];

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_off[1:0], ar_off[1:0]};
`ifndef AXI_MEM_WAIT_EN
  logic unused_wait;
  assign unused_wait = ^(32'(WAIT_CYCLES));
`endif

  // Write channel: AW and W latch independently, commit when both are present
  always_comb begin : w_next
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    aw_hit_d  = aw_hit_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
`ifdef AXI_MEM_WAIT_EN
    w_cnt_d   = w_cnt_q;
`endif
    mem_we    = 1'b0;
    aw_hs     = S_AXI_AWVALID && awready_q;
    w_hs      = S_AXI_WVALID && wready_q;
    have_aw   = aw_held_q || aw_hs;
    have_w    = w_held_q || w_hs;
    wr_idx    = aw_held_q ? aw_idx_q : aw_idx;
    wr_hit    = aw_held_q ? aw_hit_q : aw_hit;
    wr_data   = w_held_q ? wdata_q : S_AXI_WDATA;
    wr_strb   = w_held_q ? wstrb_q : S_AXI_WSTRB;
    case (w_state_q)
      W_IDLE: begin
        if (have_aw && have_w) begin
          mem_we    = wr_hit && RSTn;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bresp_d   = wr_hit ? RESP_OKAY : RESP_SLVERR;
`ifdef AXI_MEM_WAIT_EN
          if (WAIT_CYCLES == 0) begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
          end else begin
            w_state_d = W_WAIT;
            w_cnt_d   = CNT_W'(WAIT_CYCLES);
          end
`else
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
`endif
        end else begin
          if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = aw_idx;
            aw_hit_d  = aw_hit;
          end
          if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
          end
          awready_d = !have_aw;
          wready_d  = !have_w;
        end
      end
`ifdef AXI_MEM_WAIT_EN
      W_WAIT: begin
        w_cnt_d = w_cnt_q - CNT_W'(1);
        if (w_cnt_q == CNT_W'(1)) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
        end
      end
`endif
      W_RESP: begin
        if (S_AXI_BREADY) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel: one outstanding read, data captured on the AR handshake edge
  always_comb begin : r_next
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
`ifdef AXI_MEM_WAIT_EN
    r_cnt_d   = r_cnt_q;
`endif
    rd_load   = 1'b0;
    ar_hs     = S_AXI_ARVALID && arready_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          rd_load   = 1'b1;
          rresp_d   = ar_hit ? RESP_OKAY : RESP_SLVERR;
`ifdef AXI_MEM_WAIT_EN
          if (WAIT_CYCLES == 0) begin
            r_state_d = R_RESP;
            rvalid_d  = 1'b1;
          end else begin
            r_state_d = R_WAIT;
            r_cnt_d   = CNT_W'(WAIT_CYCLES);
          end
`else
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
`endif
        end
      end
`ifdef AXI_MEM_WAIT_EN
      R_WAIT: begin
        r_cnt_d = r_cnt_q - CNT_W'(1);
        if (r_cnt_q == CNT_W'(1)) begin
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
        end
      end
`endif
      R_RESP: begin
        if (S_AXI_RREADY) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          rresp_d   = RESP_OKAY;
          arready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin : state_reg
    if (!RSTn) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      aw_hit_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
`ifdef AXI_MEM_WAIT_EN
      w_cnt_q   <= '0;
      r_cnt_q   <= '0;
`endif
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      aw_hit_q  <= aw_hit_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
`ifdef AXI_MEM_WAIT_EN
      w_cnt_q   <= w_cnt_d;
      r_cnt_q   <= r_cnt_d;
`endif
    end
  end

  // Storage is never reset; byte lanes follow WSTRB
  always_ff @(posedge CLK) begin : mem_write
    for (int b = 0; b < 4; b++) begin
      if (mem_we && wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  // Same-edge read of a word being written sees the old contents
  always_ff @(posedge CLK) begin : rdata_reg
    if (!RSTn) rdata_q <= '0;
    else if (rd_load) rdata_q <= ar_hit ? mem[ar_idx] : '0;
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_lite_data_mem.sv
// Bench for axi_lite_data_mem: directed cases plus randomized AXI-Lite traffic,
// checked every cycle against a transaction-level model of the memory.
module tb_axi_lite_data_mem;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam logic [31:0] WIN   = 32'(DEPTH * 4);

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0] S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_BVALID, S_AXI_BREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0] S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;

  int checks = 0;
  int errors = 0;

  axi_lite_data_mem #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + WIN);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Transaction-level model, advanced once per cycle from what the next edge will do
  logic [31:0] mdl_mem [DEPTH];
  bit          mdl_known [DEPTH];
  bit          live = 0, rst_last = 0;
  bit          w_busy = 0, aw_got = 0, w_got = 0, r_busy = 0, exp_rknown = 0;
  logic [31:0] cap_addr, cap_data, exp_rdata;
  logic [3:0]  cap_strb;
  logic [1:0]  exp_bresp, exp_rresp;

  always @(negedge CLK) begin : compare
    bit e_awr, e_wr, e_arr;
    e_awr = !rst_last && !w_busy && !aw_got;
    e_wr  = !rst_last && !w_busy && !w_got;
    e_arr = !rst_last && !r_busy;
    if (live) begin
      chk("awready", 32'(S_AXI_AWREADY), 32'(e_awr));
      chk("wready",  32'(S_AXI_WREADY),  32'(e_wr));
      chk("arready", 32'(S_AXI_ARREADY), 32'(e_arr));
      chk("bvalid",  32'(S_AXI_BVALID),  32'(w_busy));
      chk("rvalid",  32'(S_AXI_RVALID),  32'(r_busy));
      if (rst_last) begin
        chk("bresp_rst", 32'(S_AXI_BRESP), 32'h0);
        chk("rresp_rst", 32'(S_AXI_RRESP), 32'h0);
        chk("rdata_rst", S_AXI_RDATA, 32'h0);
      end
      if (w_busy) chk("bresp", 32'(S_AXI_BRESP), 32'(exp_bresp));
      if (r_busy) begin
        chk("rresp", 32'(S_AXI_RRESP), 32'(exp_rresp));
        if (exp_rknown) chk("rdata", S_AXI_RDATA, exp_rdata);
      end
    end
    if (!RSTn) begin
      live = 1; rst_last = 1;
      w_busy = 0; aw_got = 0; w_got = 0; r_busy = 0;
    end else if (live) begin
      // read is sampled before the write of the same edge lands
      if (r_busy) begin
        if (S_AXI_RREADY) r_busy = 0;
      end else if (e_arr && S_AXI_ARVALID) begin
        r_busy = 1;
        if (in_win(S_AXI_ARADDR)) begin
          exp_rresp  = 2'b00;
          exp_rdata  = mdl_mem[word_of(S_AXI_ARADDR)];
          exp_rknown = mdl_known[word_of(S_AXI_ARADDR)];
        end else begin
          exp_rresp = 2'b10; exp_rdata = 32'h0; exp_rknown = 1;
        end
      end
      if (w_busy) begin
        if (S_AXI_BREADY) w_busy = 0;
      end else begin
        if (e_awr && S_AXI_AWVALID) begin aw_got = 1; cap_addr = S_AXI_AWADDR; end
        if (e_wr && S_AXI_WVALID) begin w_got = 1; cap_data = S_AXI_WDATA; cap_strb = S_AXI_WSTRB; end
        if (aw_got && w_got) begin
          if (in_win(cap_addr)) begin
            for (int b = 0; b < 4; b++)
              if (cap_strb[b]) mdl_mem[word_of(cap_addr)][8*b +: 8] = cap_data[8*b +: 8];
            if (cap_strb == 4'hF) mdl_known[word_of(cap_addr)] = 1;
            exp_bresp = 2'b00;
          end else begin
            exp_bresp = 2'b10;
          end
          w_busy = 1; aw_got = 0; w_got = 0;
        end
      end
      rst_last = 0;
    end
  end

  // w_lead > 0: W leads AW by that many cycles; < 0: AW leads W
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int w_lead, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, got = 0;
    int t = 0;
    resp = 2'b11;
    S_AXI_BREADY = 1; S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    while (!got && t < 60) begin
      S_AXI_AWVALID = !aw_done && (t >= (w_lead > 0 ? w_lead : 0));
      S_AXI_WVALID  = !w_done && (t >= (w_lead < 0 ? -w_lead : 0));
      @(negedge CLK);
      if (w_done && !aw_done) begin
        chk("wready_after_w", 32'(S_AXI_WREADY), 32'h0);
        chk("awready_wait_aw", 32'(S_AXI_AWREADY), 32'h1);
      end
      if (S_AXI_BVALID) begin resp = S_AXI_BRESP; got = 1; end
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
      if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1;
      @(posedge CLK); #1; t++;
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    if (!got) begin checks++; errors++; $display("FAIL wr_timeout addr=%h actual=none required=bvalid", a); end
  endtask

  task automatic rd(input logic [31:0] a, input int hold, output logic [31:0] data, output logic [1:0] resp);
    bit acc = 0, got = 0;
    int t = 0, held = 0;
    data = '0; resp = 2'b11;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1; S_AXI_RREADY = (hold == 0);
    while (!got && t < 60) begin
      @(negedge CLK);
      if (S_AXI_RVALID && S_AXI_RREADY) begin data = S_AXI_RDATA; resp = S_AXI_RRESP; got = 1; end
      if (S_AXI_ARVALID && S_AXI_ARREADY) acc = 1;
      if (S_AXI_RVALID && !S_AXI_RREADY) held++;
      @(posedge CLK); #1; t++;
      if (acc) S_AXI_ARVALID = 0;
      S_AXI_RREADY = (held >= hold);
    end
    S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    if (!got) begin checks++; errors++; $display("FAIL rd_timeout addr=%h actual=none required=rvalid", a); end
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned k = $urandom_range(0, 9);
    if (k == 0) return BASE + WIN + 32'(4 * $urandom_range(0, 15));
    if (k == 1) return BASE - 32'(4 * $urandom_range(1, 16));
    if (k == 2) return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] d;
    logic [1:0]  r;
    bit aw_acc, w_acc, ar_acc;
    RSTn = 0;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    S_AXI_AWADDR = '0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_ARADDR = '0;
    S_AXI_AWPROT = '0; S_AXI_ARPROT = '0;
    repeat (3) @(posedge CLK);
    #1 RSTn = 1;

    wr(BASE, 32'hA5A5_0001, 4'hF, 0, r);            chk("w0_resp", 32'(r), 32'h0);
    wr(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, r);   chk("w10_resp", 32'(r), 32'h0);
    rd(BASE + 32'h10, 0, d, r);                     chk("r10_data", d, 32'hDEAD_BEEF);
                                                    chk("r10_resp", 32'(r), 32'h0);
    wr(BASE + 32'h20, 32'h1122_3344, 4'hF, -2, r);  chk("w20_resp", 32'(r), 32'h0);
    wr(BASE + 32'h20, 32'h0000_AB00, 4'b0010, 3, r); chk("w20_strb_resp", 32'(r), 32'h0);
    rd(BASE + 32'h20, 0, d, r);                     chk("r20_merge", d, 32'h1122_AB44);
    rd(BASE + WIN, 0, d, r);                        chk("roor_data", d, 32'h0);
                                                    chk("roor_resp", 32'(r), 32'h2);
    wr(BASE + WIN, 32'hFFFF_FFFF, 4'hF, 0, r);      chk("woor_resp", 32'(r), 32'h2);
    rd(BASE, 0, d, r);                              chk("r0_untouched", d, 32'hA5A5_0001);
    wr(BASE + 32'h10, 32'h0, 4'h0, 0, r);           chk("wstrb0_resp", 32'(r), 32'h0);
    rd(BASE + 32'h13, 5, d, r);                     chk("r10_hold", d, 32'hDEAD_BEEF);
                                                    chk("r10_hold_resp", 32'(r), 32'h0);

    // reset while a write response is pending
    S_AXI_BREADY = 0;
    S_AXI_AWADDR = BASE + 32'h30; S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    @(posedge CLK); #1; S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    @(negedge CLK); chk("bvalid_pre_rst", 32'(S_AXI_BVALID), 32'h1);
    @(posedge CLK); #1 RSTn = 0;
    @(posedge CLK); #1 RSTn = 1;
    @(negedge CLK); chk("bvalid_post_rst", 32'(S_AXI_BVALID), 32'h0);
    repeat (3) begin @(negedge CLK); chk("bvalid_stale", 32'(S_AXI_BVALID), 32'h0); end
    @(posedge CLK); #1;
    wr(BASE + 32'h34, 32'h7777_8888, 4'hF, 0, r);   chk("w_after_rst", 32'(r), 32'h0);
    rd(BASE + 32'h30, 0, d, r);                     chk("r30_kept", d, 32'h0BAD_F00D);

    // randomized traffic with one mid-run reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLK);
      aw_acc = S_AXI_AWVALID && S_AXI_AWREADY;
      w_acc  = S_AXI_WVALID && S_AXI_WREADY;
      ar_acc = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge CLK); #1;
      RSTn = (cyc != 1500);
      if (aw_acc || !S_AXI_AWVALID) begin
        S_AXI_AWVALID = ($urandom_range(0, 2) == 0);
        S_AXI_AWADDR  = rnd_addr();
        S_AXI_AWPROT  = 3'($urandom);
      end
      if (w_acc || !S_AXI_WVALID) begin
        S_AXI_WVALID = ($urandom_range(0, 2) == 0);
        S_AXI_WDATA  = $urandom;
        S_AXI_WSTRB  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      end
      if (ar_acc || !S_AXI_ARVALID) begin
        S_AXI_ARVALID = ($urandom_range(0, 1) == 0);
        S_AXI_ARADDR  = rnd_addr();
        S_AXI_ARPROT  = 3'($urandom);
      end
      S_AXI_BREADY = ($urandom_range(0, 3) != 0);
      S_AXI_RREADY = ($urandom_range(0, 3) != 0);
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    repeat (10) @(posedge CLK);
    #1;
    rd(BASE + 32'h20, 0, d, r);
    if (mdl_known[8]) chk("r20_final", d, mdl_mem[8]);
    chk("r20_final_resp", 32'(r), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
